// File: rtl/pid_pkg.sv
// Shared types and constants for the PID datapath.
package pid_pkg;

  localparam int unsigned PID_W = 16;

  typedef logic signed [PID_W-1:0] pid_data_t;

  localparam pid_data_t PID_MAX         = 16'sh7FFF;
  localparam pid_data_t PID_MIN         = 16'sh8000;
  localparam pid_data_t PID_INTEG_LIMIT = 16'sd8192;

endpackage

// File: rtl/pid_sat_addsub.sv
// Combinational saturating add/subtract with parameterised clamp bounds.
// Result is formed one bit wider than the operands so it never wraps before the clamp.
module pid_sat_addsub #(
  parameter int unsigned             WIDTH = 16,
  parameter logic signed [WIDTH-1:0] LO    = {1'b1, {(WIDTH-1){1'b0}}},
  parameter logic signed [WIDTH-1:0] HI    = {1'b0, {(WIDTH-1){1'b1}}}
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic                    sub_i,
  output logic signed [WIDTH-1:0] y_o,
  output logic                    ovf_o
);

  localparam logic signed [WIDTH:0] LO_X = $signed({LO[WIDTH-1], LO});
  localparam logic signed [WIDTH:0] HI_X = $signed({HI[WIDTH-1], HI});

  logic signed [WIDTH:0] a_x;
  logic signed [WIDTH:0] b_x;
  logic signed [WIDTH:0] r_x;

  always_comb begin
    a_x = $signed({a_i[WIDTH-1], a_i});
    b_x = $signed({b_i[WIDTH-1], b_i});
    r_x = sub_i ? (a_x - b_x) : (a_x + b_x);
  end

  always_comb begin
    y_o   = r_x[WIDTH-1:0];
    ovf_o = 1'b0;
    if (r_x > HI_X) begin
      y_o   = HI;
      ovf_o = 1'b1;
    end else if (r_x < LO_X) begin
      y_o   = LO;
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/pid_error_tracker.sv
// PID front end: saturated error, clamped integral and first difference, 2-stage pipeline.
// Define PID_ANTIWINDUP_EN to clamp the integral to +/-INTEG_LIMIT instead of the full range.
module pid_error_tracker
  import pid_pkg::*;
#(
  parameter int unsigned             WIDTH       = PID_W,
  parameter logic signed [WIDTH-1:0] INTEG_LIMIT = PID_INTEG_LIMIT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] setpoint,
  input  logic signed [WIDTH-1:0] measurement,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] err,
  output logic signed [WIDTH-1:0] integ,
  output logic signed [WIDTH-1:0] deriv,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic signed [WIDTH-1:0] FULL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] FULL_MIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef PID_ANTIWINDUP_EN
  localparam logic signed [WIDTH-1:0] INT_HI = INTEG_LIMIT;
  localparam logic signed [WIDTH-1:0] INT_LO = -INTEG_LIMIT;
`else
  localparam logic signed [WIDTH-1:0] INT_HI = FULL_MAX;
  localparam logic signed [WIDTH-1:0] INT_LO = FULL_MIN;
`endif

  logic                    s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0] s1_err_q,   s1_err_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] err_q,      err_d;
  logic signed [WIDTH-1:0] integ_q,    integ_d;
  logic signed [WIDTH-1:0] deriv_q,    deriv_d;
  logic                    out_sat_q,  out_sat_d;
  logic signed [WIDTH-1:0] prev_err_q, prev_err_d;
  logic                    first_q,    first_d;

  logic                    stall;
  logic                    accept;
  logic signed [WIDTH-1:0] e_sat;
  logic signed [WIDTH-1:0] integ_sum;
  logic                    integ_clamped;
  logic signed [WIDTH-1:0] diff_sat;
  logic                    err_ovf_unused;
  logic                    diff_ovf_unused;

  pid_sat_addsub #(
    .WIDTH (WIDTH),
    .LO    (FULL_MIN),
    .HI    (FULL_MAX)
  ) u_err (
    .a_i   (setpoint),
    .b_i   (measurement),
    .sub_i (1'b1),
    .y_o   (e_sat),
    .ovf_o (err_ovf_unused)
  );

  pid_sat_addsub #(
    .WIDTH (WIDTH),
    .LO    (INT_LO),
    .HI    (INT_HI)
  ) u_integ (
    .a_i   (integ_q),
    .b_i   (s1_err_q),
    .sub_i (1'b0),
    .y_o   (integ_sum),
    .ovf_o (integ_clamped)
  );

  pid_sat_addsub #(
    .WIDTH (WIDTH),
    .LO    (FULL_MIN),
    .HI    (FULL_MAX)
  ) u_deriv (
    .a_i   (s1_err_q),
    .b_i   (prev_err_q),
    .sub_i (1'b1),
    .y_o   (diff_sat),
    .ovf_o (diff_ovf_unused)
  );

  // in_ready is gated by the async reset directly so it drops with reset, not at the next edge.
  always_comb begin
    stall    = out_valid_q & ~out_ready;
    in_ready = reset & ~stall & ~clear;
    accept   = in_valid & in_ready;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    integ_d     = integ_q;
    deriv_d     = deriv_q;
    out_sat_d   = out_sat_q;
    prev_err_d  = prev_err_q;
    first_d     = first_q;
    if (clear) begin
      s1_valid_d  = 1'b0;
      s1_err_d    = '0;
      out_valid_d = 1'b0;
      err_d       = '0;
      integ_d     = '0;
      deriv_d     = '0;
      out_sat_d   = 1'b0;
      prev_err_d  = '0;
      first_d     = 1'b1;
    end else if (!stall) begin
      s1_valid_d  = accept;
      if (accept) s1_err_d = e_sat;
      out_valid_d = s1_valid_q;
      // Integral and derivative history advance only when a real sample enters S2.
      if (s1_valid_q) begin
        err_d      = s1_err_q;
        integ_d    = integ_sum;
        out_sat_d  = integ_clamped;
        deriv_d    = first_q ? '0 : diff_sat;
        prev_err_d = s1_err_q;
        first_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
      integ_q     <= '0;
      deriv_q     <= '0;
      out_sat_q   <= 1'b0;
      prev_err_q  <= '0;
      first_q     <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      integ_q     <= integ_d;
      deriv_q     <= deriv_d;
      out_sat_q   <= out_sat_d;
      prev_err_q  <= prev_err_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    err       = err_q;
    integ     = integ_q;
    deriv     = deriv_q;
    out_sat   = out_sat_q;
    out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_pid_error_tracker.sv
// Bench for pid_error_tracker: hand-computed vectors, directed corner sequences, random traffic vs a model.
module tb_pid_error_tracker;

`ifdef PID_ANTIWINDUP_EN
  localparam int I_LO = -8192;
  localparam int I_HI = 8192;
`else
  localparam int I_LO = -32768;
  localparam int I_HI = 32767;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic signed [15:0] setpoint;
  logic signed [15:0] measurement;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] err;
  logic signed [15:0] integ;
  logic signed [15:0] deriv;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;

  pid_error_tracker #(
    .WIDTH       (16),
    .INTEG_LIMIT (16'sd8192)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .setpoint    (setpoint),
    .measurement (measurement),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .err         (err),
    .integ       (integ),
    .deriv       (deriv),
    .out_sat     (out_sat),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted sample's result is computed in order at acceptance time.
  typedef struct {
    int e;
    int i;
    int d;
    int s;
  } exp_t;

  exp_t mq[$];
  int   m_acc, m_prev, m_first;
  int   n_acc = 0;
  int   n_out = 0;

  function automatic int satr(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_acc   = 0;
    m_prev  = 0;
    m_first = 1;
  endfunction

  function automatic void model_push(input int sp, input int ms);
    exp_t x;
    int   raw;
    x.e     = satr(sp - ms, -32768, 32767);
    raw     = m_acc + x.e;
    x.s     = (raw > I_HI || raw < I_LO) ? 1 : 0;
    m_acc   = satr(raw, I_LO, I_HI);
    x.i     = m_acc;
    x.d     = m_first ? 0 : satr(x.e - m_prev, -32768, 32767);
    m_prev  = x.e;
    m_first = 0;
    mq.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      check("integ_in_bounds", (integ >= I_LO && integ <= I_HI) ? 1 : 0, 1);
      if (mq.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("mon_err", err, mq[0].e);
        check("mon_integ", integ, mq[0].i);
        check("mon_deriv", deriv, mq[0].d);
        check("mon_sat", out_sat, mq[0].s);
        if (out_ready) begin
          void'(mq.pop_front());
          n_out++;
        end
      end
      if (!out_ready) check("in_ready_stall", in_ready, 0);
    end
    if (!reset || clear) begin
      model_reset();
    end else if (in_valid && in_ready) begin
      model_push(setpoint, measurement);
      n_acc++;
    end
  end

  function automatic logic signed [15:0] rnd16();
    int t;
    case ($urandom_range(0, 7))
      0:       t = 32767;
      1:       t = -32768;
      2, 3:    t = int'($urandom_range(0, 65535)) - 32768;
      default: t = int'($urandom_range(0, 400)) - 200;
    endcase
    return t[15:0];
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic send(input logic signed [15:0] sp, input logic signed [15:0] ms, output bit ok);
    setpoint    = sp;
    measurement = ms;
    in_valid    = 1'b1;
    ok          = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("send_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  // Counts rising edges (including the accepting one) until out_valid; returns at that falling edge.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("out_valid_timeout", 0, 1);
  endtask

  typedef struct {
    logic signed [15:0] sp;
    logic signed [15:0] ms;
    int e;
    int i;
    int d;
    int s;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit ok;
    int lat;
    int sent;
    int base;
    int cyc;

    tbl[0] = '{16'sd100,    16'sd40,     60,     60,     0,      0};
    tbl[1] = '{16'sd100,    16'sd70,     30,     90,     -30,    0};
`ifdef PID_ANTIWINDUP_EN
    tbl[2] = '{16'sh8000,   16'sh7FFF,   -32768, -8192,  -32768, 1};
    tbl[3] = '{16'sd0,      16'sd0,      0,      -8192,  32767,  0};
    tbl[4] = '{16'sh7FFF,   16'sh8000,   32767,  8192,   32767,  1};
    tbl[5] = '{16'sh7FFF,   16'sh8000,   32767,  8192,   0,      1};
    tbl[6] = '{16'sd5,      16'sd10,     -5,     8187,   -32768, 0};
`else
    tbl[2] = '{16'sh8000,   16'sh7FFF,   -32768, -32678, -32768, 0};
    tbl[3] = '{16'sd0,      16'sd0,      0,      -32678, 32767,  0};
    tbl[4] = '{16'sh7FFF,   16'sh8000,   32767,  89,     32767,  0};
    tbl[5] = '{16'sh7FFF,   16'sh8000,   32767,  32767,  0,      1};
    tbl[6] = '{16'sd5,      16'sd10,     -5,     32762,  -32768, 0};
`endif

    reset       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    setpoint    = '0;
    measurement = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_integ", integ, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 7; r++) begin
      send(tbl[r].sp, tbl[r].ms, ok);
      if (ok) begin
        wait_out(lat);
        check("tbl_latency", lat, 2);
        check("tbl_err", err, tbl[r].e);
        check("tbl_integ", integ, tbl[r].i);
        check("tbl_deriv", deriv, tbl[r].d);
        check("tbl_sat", out_sat, tbl[r].s);
        @(posedge clk);
        #1;
      end
    end

    // Async reset while a stalled result is presented.
    out_ready = 1'b0;
    send(16'sd123, 16'sd23, ok);
    wait_out(lat);
    check("rst_pre_out_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_integ", integ, 0);
    check("rst_deriv", deriv, 0);
    check("rst_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    send(16'sd50, 16'sd20, ok);
    wait_out(lat);
    check("rst_first_err", err, 30);
    check("rst_first_integ", integ, 30);
    check("rst_first_deriv", deriv, 0);
    @(posedge clk);
    #1;

    // Backpressure: five stalled cycles while feeding ten samples.
    base        = n_out;
    sent        = 0;
    in_valid    = 1'b1;
    setpoint    = rnd16();
    measurement = rnd16();
    for (int c = 0; c < 200 && sent < 10; c++) begin
      out_ready = (c < 2 || c >= 7);
      @(negedge clk);
      ok = in_ready;
      if (ok) sent++;
      @(posedge clk);
      #1;
      if (ok) begin
        setpoint    = rnd16();
        measurement = rnd16();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("bp_sent", sent, 10);
    check("bp_outputs", n_out - base, 10);
    check("bp_queue_empty", mq.size(), 0);

    // Clear with two samples in flight under backpressure.
    out_ready = 1'b0;
    send(16'sd300, 16'sd100, ok);
    send(16'sd10, 16'sd20, ok);
    check("clr_pre_out_valid", out_valid, 1);
    clear       = 1'b1;
    in_valid    = 1'b1;
    setpoint    = 16'sd77;
    measurement = 16'sd0;
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("clr_out_valid", out_valid, 0);
    check("clr_integ", integ, 0);
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(16'sd5, 16'sd0, ok);
    wait_out(lat);
    check("clr_next_err", err, 5);
    check("clr_next_integ", integ, 5);
    check("clr_next_deriv", deriv, 0);
    @(posedge clk);
    #1;

    // Random traffic against the model.
    base = n_acc;
    for (cyc = 0; cyc < 60000 && (n_acc - base) < 10000; cyc++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      clear       = ($urandom_range(0, 499) == 0);
      setpoint    = rnd16();
      measurement = rnd16();
      @(posedge clk);
      #1;
    end
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_samples", ((n_acc - base) >= 10000) ? 1 : 0, 1);
    check("rand_drain_empty", mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
